// File: rtl/sec_key_sequencer.sv
// Sequencer for the keyed SEC core: serial key provisioning with parity-checked commit,
// and a one-word-in-flight valid/ready front end that registers core inputs and captures outputs.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | no transaction; accepts a word when a key is live and no commit is pending
// SETTLE_WAIT | core inputs registered, counting down until the core output is stable
// OUT_HOLD    | corrected word captured, held until downstream accepts it
module sec_key_sequencer #(
    parameter int KEY_W  = 20,
    parameter int IN_W   = 41,
    parameter int OUT_W  = 32,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_sdi_i,
    input  logic              key_sen_i,
    input  logic              key_commit_i,
    output logic [KEY_W-1:0]  key_o,
    output logic              key_ok_o,
    output logic              key_err_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [IN_W-1:0]   in_data_i,
    output logic [IN_W-1:0]   core_din_o,
    input  logic [OUT_W-1:0]  core_dout_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OUT_W-1:0]  out_data_o,
    output logic              busy_o
);

    localparam int CNT_W    = $clog2(KEY_W + 2);
    localparam int SETTLE_W = 4;
    localparam logic [CNT_W-1:0]    BITS_FULL  = CNT_W'(KEY_W + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LDV = SETTLE_W'(SETTLE);

    typedef enum logic [1:0] {IDLE, SETTLE_WAIT, OUT_HOLD} state_t;

    state_t               state_q, state_d;
    logic [KEY_W:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic [KEY_W-1:0]     pend_key_q, pend_key_d;
    logic                 key_ok_q, key_ok_d;
    logic                 key_err_q, key_err_d;
    logic                 pend_q, pend_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [IN_W-1:0]      core_din_q, core_din_d;
    logic [OUT_W-1:0]     out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 commit_ok;
    logic                 in_ready;

    assign commit_ok = (bit_cnt_q == BITS_FULL) && !(^shadow_q);
    assign in_ready  = (state_q == IDLE) && key_ok_q && !pend_q;

    always_comb begin
        shadow_d   = shadow_q;
        bit_cnt_d  = bit_cnt_q;
        key_d      = key_q;
        key_ok_d   = key_ok_q;
        key_err_d  = 1'b0;
        pend_d     = pend_q;
        pend_key_d = pend_key_q;

        if (pend_q && state_q == IDLE) begin
            key_d    = pend_key_q;
            key_ok_d = 1'b1;
            pend_d   = 1'b0;
        end

        // Commit sees the pre-shift shadow and count; a same-cycle shift then starts a fresh count.
        if (key_commit_i) begin
            bit_cnt_d = '0;
            if (!commit_ok) begin
                key_err_d = 1'b1;
            end else if (state_q == IDLE) begin
                key_d    = shadow_q[KEY_W:1];
                key_ok_d = 1'b1;
                pend_d   = 1'b0;
            end else begin
                pend_d     = 1'b1;
                pend_key_d = shadow_q[KEY_W:1];
            end
        end

        if (key_sen_i) begin
            shadow_d = {shadow_q[KEY_W-1:0], key_sdi_i};
            if (key_commit_i) begin
                bit_cnt_d = CNT_W'(1);
            end else begin
                pend_d = 1'b0;
                if (bit_cnt_q != BITS_FULL) bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        core_din_d  = core_din_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready) begin
                    core_din_d = in_data_i;
                    settle_d   = SETTLE_LDV;
                    state_d    = SETTLE_WAIT;
                end
            end
            SETTLE_WAIT: begin
                // Loaded with SETTLE so the capture lands SETTLE+1 edges after acceptance.
                if (settle_q == '0) begin
                    out_data_d  = core_dout_i;
                    out_valid_d = 1'b1;
                    state_d     = OUT_HOLD;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            OUT_HOLD: begin
                if (out_valid_q && out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            bit_cnt_q   <= '0;
            key_q       <= '0;
            pend_key_q  <= '0;
            key_ok_q    <= 1'b0;
            key_err_q   <= 1'b0;
            pend_q      <= 1'b0;
            settle_q    <= '0;
            core_din_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            bit_cnt_q   <= bit_cnt_d;
            key_q       <= key_d;
            pend_key_q  <= pend_key_d;
            key_ok_q    <= key_ok_d;
            key_err_q   <= key_err_d;
            pend_q      <= pend_d;
            settle_q    <= settle_d;
            core_din_q  <= core_din_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign key_o       = key_q;
    assign key_ok_o    = key_ok_q;
    assign key_err_o   = key_err_q;
    assign in_ready_o  = in_ready;
    assign core_din_o  = core_din_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_sec_key_sequencer.sv
// Bench for sec_key_sequencer: table of codewords through an identity core stub,
// plus hand-written key commit, hold, pending-commit and mid-transaction reset sequences.
module tb_sec_key_sequencer;

    localparam int KEY_W = 20;
    localparam int IN_W  = 41;
    localparam int OUT_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              key_sdi, key_sen, key_commit;
    logic [KEY_W-1:0]  key;
    logic              key_ok, key_err;
    logic              in_valid, in_ready;
    logic [IN_W-1:0]   in_data;
    logic [IN_W-1:0]   core_din;
    logic [OUT_W-1:0]  core_dout;
    logic              out_valid, out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              busy;
    logic [OUT_W-1:0]  stub_mask;

    int n_vec = 0;
    int n_err = 0;
    logic [OUT_W-1:0] sb[$];

    typedef struct {
        logic [IN_W-1:0]  din;
        logic [OUT_W-1:0] exp;
    } vec_t;
    vec_t tbl[4];

    always #5 clk = ~clk;

    // Core stub: identity on the low 32 bits; the mask lets the hold test disturb it.
    assign core_dout = core_din[OUT_W-1:0] ^ stub_mask;

    sec_key_sequencer #(.KEY_W(KEY_W), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_sdi_i(key_sdi), .key_sen_i(key_sen), .key_commit_i(key_commit),
        .key_o(key), .key_ok_o(key_ok), .key_err_o(key_err),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .core_din_o(core_din), .core_dout_i(core_dout),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .busy_o(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic shift_key(input logic [KEY_W-1:0] k, input logic par, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            key_sen = 1'b1;
            key_sdi = (i < KEY_W) ? k[KEY_W-1-i] : par;
            tick();
        end
        key_sen = 1'b0;
        key_sdi = 1'b0;
    endtask

    task automatic commit();
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
    endtask

    task automatic send_word(input logic [IN_W-1:0] d, input logic [OUT_W-1:0] exp);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        sb.push_back(exp);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic recv(input string name);
        logic [OUT_W-1:0] e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({name, "_data"}, {32'd0, out_data}, {32'd0, e});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [OUT_W-1:0] held;

        tbl[0] = '{41'h0_FF_12345678, 32'h12345678};
        tbl[1] = '{41'h1_00_FFFFFFFF, 32'hFFFFFFFF};
        tbl[2] = '{41'h0_00_00000000, 32'h00000000};
        tbl[3] = '{41'h1_AB_DEADBEEF, 32'hDEADBEEF};

        rst_n = 1'b0; key_sdi = 0; key_sen = 0; key_commit = 0;
        in_valid = 0; in_data = '0; out_ready = 0; stub_mask = '0;
        tick(); tick();
        check("rst_key", {44'd0, key}, 64'd0);
        check("rst_key_ok", {63'd0, key_ok}, 64'd0);
        check("rst_key_err", {63'd0, key_err}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_core_din", {23'd0, core_din}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        tick();

        // No key yet: in_valid must be ignored.
        in_valid = 1'b1; in_data = 41'h0_00_11111111;
        tick(); tick(); tick();
        check("nokey_in_ready", {63'd0, in_ready}, 64'd0);
        check("nokey_busy", {63'd0, busy}, 64'd0);
        in_valid = 1'b0;

        shift_key(20'hA5A5A, 1'b0, 21);
        commit();
        check("load_key", {44'd0, key}, 64'h A5A5A);
        check("load_key_ok", {63'd0, key_ok}, 64'd1);
        check("load_in_ready", {63'd0, in_ready}, 64'd1);
        check("load_key_err", {63'd0, key_err}, 64'd0);

        shift_key(20'hA5A5A, 1'b1, 21);
        commit();
        check("badpar_err", {63'd0, key_err}, 64'd1);
        check("badpar_key", {44'd0, key}, 64'hA5A5A);
        check("badpar_key_ok", {63'd0, key_ok}, 64'd1);
        tick();
        check("badpar_err_pulse", {63'd0, key_err}, 64'd0);

        // Only 20 bits after a rejected commit: would be a valid key 0x80000 if the count survived.
        shift_key(20'h00001, 1'b0, 20);
        commit();
        check("cntclr_err", {63'd0, key_err}, 64'd1);
        check("cntclr_key", {44'd0, key}, 64'hA5A5A);
        tick();

        shift_key(20'hA5A5A, 1'b0, 19);
        commit();
        check("short_err", {63'd0, key_err}, 64'd1);
        check("short_key", {44'd0, key}, 64'hA5A5A);
        tick();

        for (int i = 0; i < 4; i++) begin
            send_word(tbl[i].din, tbl[i].exp);
            check("tbl_busy", {63'd0, busy}, 64'd1);
            check("tbl_in_ready", {63'd0, in_ready}, 64'd0);
            check("tbl_core_din", {23'd0, core_din}, {23'd0, tbl[i].din});
            wait_out(lat);
            check("tbl_latency", 64'(lat), 64'd3);
            recv("tbl");
        end

        send_word(41'h0_00_CAFEF00D, 32'hCAFEF00D);
        wait_out(lat);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            stub_mask = $urandom | 32'h1;
            tick();
            check("hold_data", {32'd0, out_data}, 64'hCAFEF00D);
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        stub_mask = '0;
        recv("hold");
        check("hold_idle", {63'd0, busy}, 64'd0);

        shift_key(20'h00001, 1'b1, 21);
        send_word(41'h0_00_00000055, 32'h00000055);
        commit();
        check("pend_key_sw", {44'd0, key}, 64'hA5A5A);
        check("pend_busy", {63'd0, busy}, 64'd1);
        wait_out(lat);
        tick(); tick();
        check("pend_key_hold", {44'd0, key}, 64'hA5A5A);
        recv("pend");
        check("pend_entry_busy", {63'd0, busy}, 64'd0);
        check("pend_entry_in_ready", {63'd0, in_ready}, 64'd0);
        check("pend_entry_key", {44'd0, key}, 64'hA5A5A);
        tick();
        check("pend_applied_key", {44'd0, key}, 64'h00001);
        check("pend_applied_in_ready", {63'd0, in_ready}, 64'd1);
        send_word(41'h1_5A_0BADCAFE, 32'h0BADCAFE);
        check("newkey_busy_key", {44'd0, key}, 64'h00001);
        wait_out(lat);
        recv("newkey");

        send_word(41'h0_00_77777777, 32'h77777777);
        tick();
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_key", {44'd0, key}, 64'd0);
        check("midrst_key_ok", {63'd0, key_ok}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out_data", {32'd0, out_data}, 64'd0);
        check("midrst_core_din", {23'd0, core_din}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 41'h0_00_22222222;
        tick(); tick(); tick();
        check("postrst_in_ready", {63'd0, in_ready}, 64'd0);
        check("postrst_busy", {63'd0, busy}, 64'd0);
        in_valid = 1'b0;
        shift_key(20'hA5A5A, 1'b0, 21);
        commit();
        check("reload_in_ready", {63'd0, in_ready}, 64'd1);
        send_word(41'h0_12_89ABCDEF, 32'h89ABCDEF);
        wait_out(lat);
        check("reload_latency", 64'(lat), 64'd3);
        recv("reload");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
